// File: rtl/exp_3x3_ker_write_cont_if.sv
// exp_3x3_ker_write_cont_if: kernel stream, RAM write port and layer handshake bundle
interface exp_3x3_ker_write_cont_if;
   logic        start_i;
   logic [5:0]  ker_words_i;
   logic [5:0]  ker_loads_i;
   logic        ker_data_valid_i;
   logic [71:0] ker_data_i;
   logic        ker_data_ready_o;
   logic        exp_3x3_ram_wr_en_o;
   logic [6:0]  exp_3x3_ram_wr_addr_o;
   logic [71:0] exp_3x3_ram_wr_data_o;
   logic        layer_1_ready_o;
   logic        layer_2_ready_o;
   logic        layer_1_done_i;
   logic        layer_2_done_i;
   logic        load_done_o;
   modport slave (
      input  start_i, ker_words_i, ker_loads_i, ker_data_valid_i, ker_data_i,
             layer_1_done_i, layer_2_done_i,
      output ker_data_ready_o, exp_3x3_ram_wr_en_o, exp_3x3_ram_wr_addr_o,
             exp_3x3_ram_wr_data_o, layer_1_ready_o, layer_2_ready_o, load_done_o
   );
   modport master (
      output start_i, ker_words_i, ker_loads_i, ker_data_valid_i, ker_data_i,
             layer_1_done_i, layer_2_done_i,
      input  ker_data_ready_o, exp_3x3_ram_wr_en_o, exp_3x3_ram_wr_addr_o,
             exp_3x3_ram_wr_data_o, layer_1_ready_o, layer_2_ready_o, load_done_o
   );
endinterface

// File: rtl/exp_3x3_ker_write_cont.sv
// exp_3x3_ker_write_cont: writes kernel stream into a two-layer ping-pong RAM
module exp_3x3_ker_write_cont (
   input logic clk_i,
   input logic rst_i,
   exp_3x3_ker_write_cont_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FILL, WAIT_FREE} state_t;
   state_t      state, state_nx;
   logic [5:0]  words, loads, word_cnt, load_cnt;
   logic        tgt, fin, fin_last, xfer, last, wr_en, load_done;
   logic [1:0]  rdy, rdy_nx, done;
   logic [6:0]  wr_addr;
   logic [71:0] wr_data;
   assign bus.ker_data_ready_o      = state == FILL;
   assign bus.exp_3x3_ram_wr_en_o   = wr_en;
   assign bus.exp_3x3_ram_wr_addr_o = wr_addr;
   assign bus.exp_3x3_ram_wr_data_o = wr_data;
   assign bus.layer_1_ready_o       = rdy[0];
   assign bus.layer_2_ready_o       = rdy[1];
   assign bus.load_done_o           = load_done;
   assign xfer = bus.ker_data_valid_i & bus.ker_data_ready_o;
   assign last = xfer & (word_cnt == words);
   assign done = {bus.layer_2_done_i, bus.layer_1_done_i};
   // fin marks the cycle after a layer's last transfer; tgt already points at the next layer
   always_comb begin
      rdy_nx = rdy & ~done;
      if (fin) rdy_nx[~tgt] = 1'b1;
      state_nx = state;
      if (bus.start_i) state_nx = FILL;
      else if (last) state_nx = WAIT_FREE;
      else if (state == WAIT_FREE) state_nx = (fin && fin_last) ? IDLE : rdy_nx[tgt] ? WAIT_FREE : FILL;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         words     <= '0;
         loads     <= '0;
         word_cnt  <= '0;
         load_cnt  <= '0;
         tgt       <= 1'b0;
         fin       <= 1'b0;
         fin_last  <= 1'b0;
         rdy       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         load_done <= 1'b0;
      end else begin
         state     <= state_nx;
         wr_en     <= xfer & ~bus.start_i;
         fin       <= last & ~bus.start_i;
         load_done <= fin & fin_last & ~bus.start_i;
         if (bus.start_i) begin
            words    <= bus.ker_words_i;
            loads    <= bus.ker_loads_i;
            word_cnt <= '0;
            load_cnt <= '0;
            tgt      <= 1'b0;
            rdy      <= '0;
         end else begin
            rdy <= rdy_nx;
            if (xfer) begin
               wr_addr  <= {tgt, word_cnt};
               wr_data  <= bus.ker_data_i;
               word_cnt <= last ? 6'd0 : word_cnt + 6'd1;
            end
            if (last) begin
               tgt      <= ~tgt;
               load_cnt <= load_cnt + 6'd1;
               fin_last <= load_cnt == loads;
            end
         end
      end
   end
endmodule

// File: tb/tb_exp_3x3_ker_write_cont.sv
// tb_exp_3x3_ker_write_cont: random and directed stimulus against a word-count based reference model
module tb_exp_3x3_ker_write_cont;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   exp_3x3_ker_write_cont_if bus();
   exp_3x3_ker_write_cont dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
   always #5 clk_i = ~clk_i;
   int vecs = 0, errs = 0;
   int m_w, m_l, m_n;
   bit m_on, m_gap, m_gap_lay, m_gap_last, e_wr, e_done;
   bit [1:0] m_flag;
   logic [6:0] e_addr;
   logic [71:0] e_data;
   // the model tracks only the count of accepted words since start; layer, address and load follow by arithmetic
   function automatic int total();
      return (m_l + 1) * (m_w + 1);
   endfunction
   function automatic bit tgt();
      return ((m_n / (m_w + 1)) % 2) == 1;
   endfunction
   function automatic bit acc();
      return m_on && !m_gap && m_n < total() && !m_flag[tgt()];
   endfunction
   task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_outs();
      chk("ker_data_ready", 72'(bus.ker_data_ready_o), 72'(acc()));
      chk("wr_en", 72'(bus.exp_3x3_ram_wr_en_o), 72'(e_wr));
      chk("wr_addr", 72'(bus.exp_3x3_ram_wr_addr_o), 72'(e_addr));
      chk("wr_data", bus.exp_3x3_ram_wr_data_o, e_data);
      chk("layer_1_ready", 72'(bus.layer_1_ready_o), 72'(m_flag[0]));
      chk("layer_2_ready", 72'(bus.layer_2_ready_o), 72'(m_flag[1]));
      chk("load_done", 72'(bus.load_done_o), 72'(e_done));
   endtask
   task automatic model_reset();
      m_on = 0; m_n = 0; m_w = 0; m_l = 0; m_flag = 0; m_gap = 0; m_gap_lay = 0; m_gap_last = 0;
      e_wr = 0; e_done = 0; e_addr = '0; e_data = '0;
   endtask
   task automatic step(bit st, bit v, bit d1, bit d2, logic [5:0] w = 6'd0, logic [5:0] l = 6'd0);
      logic [95:0] r;
      bit x, t;
      r = {$urandom(), $urandom(), $urandom()};
      bus.start_i = st; bus.ker_words_i = w; bus.ker_loads_i = l;
      bus.ker_data_valid_i = v; bus.ker_data_i = r[71:0];
      bus.layer_1_done_i = d1; bus.layer_2_done_i = d2;
      #4;
      check_outs();
      t = tgt();
      x = acc() && v;
      e_wr = x && !st;
      if (e_wr) begin
         e_addr = {t, 6'(m_n % (m_w + 1))};
         e_data = r[71:0];
      end
      if (st) begin
         m_on = 1; m_w = int'(w); m_l = int'(l); m_n = 0; m_flag = 0; m_gap = 0; e_done = 0;
      end else begin
         e_done = m_gap && m_gap_last;
         m_flag = m_flag & ~{d2, d1};
         if (m_gap) m_flag[m_gap_lay] = 1'b1;
         m_gap = x && (m_n % (m_w + 1) == m_w);
         m_gap_lay = t;
         if (x) m_n++;
         m_gap_last = m_n == total();
      end
      @(posedge clk_i);
      #1;
   endtask
   initial begin
      bus.start_i = 0; bus.ker_words_i = 0; bus.ker_loads_i = 0; bus.ker_data_valid_i = 0;
      bus.ker_data_i = '0; bus.layer_1_done_i = 0; bus.layer_2_done_i = 0;
      model_reset();
      #3;
      check_outs();
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      repeat (3) step(0, 1, 0, 0);
      // single load of four words, then IDLE with layer 1 ready and one load_done pulse
      step(1, 0, 0, 0, 6'd3, 6'd0);
      repeat (4) step(0, 1, 0, 0);
      repeat (4) step(0, 1, 0, 0);
      // four loads of two words with no consumer until the writer stalls
      step(1, 0, 0, 0, 6'd1, 6'd3);
      repeat (10) step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      repeat (6) step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      repeat (6) step(0, 1, 0, 0);
      // valid on alternate cycles
      step(1, 0, 0, 0, 6'd5, 6'd1);
      for (int i = 0; i < 40; i++) step(0, i % 2 == 1, i == 25, 0);
      // restart two words into a layer
      step(1, 0, 0, 0, 6'd7, 6'd2);
      repeat (2) step(0, 1, 0, 0);
      step(1, 1, 0, 0, 6'd7, 6'd2);
      repeat (4) step(0, 1, 0, 0);
      // layer 2 done coinciding with its completion, plus a stray layer 1 done
      step(1, 0, 0, 0, 6'd1, 6'd3);
      for (int i = 0; i < 14; i++) step(0, 1, i == 0, m_gap && m_gap_lay);
      // randomized traffic with occasional restarts
      for (int k = 0; k < 6; k++) begin
         step(1, 0, 0, 0, 6'($urandom_range(0, 5)), 6'($urandom_range(0, 4)));
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 59) == 0)
               step(1, $urandom_range(0, 1) == 1, 0, 0, 6'($urandom_range(0, 5)), 6'($urandom_range(0, 4)));
            else
               step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         end
      end
      // asynchronous reset in the middle of a stream
      step(1, 0, 0, 0, 6'd9, 6'd1);
      repeat (3) step(0, 1, 0, 0);
      bus.start_i = 0; bus.ker_data_valid_i = 1; bus.layer_1_done_i = 0; bus.layer_2_done_i = 0;
      #2 rst_i = 1'b1;
      #1;
      model_reset();
      check_outs();
      @(posedge clk_i);
      #3;
      check_outs();
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      repeat (5) step(0, 1, 0, 0);
      step(1, 0, 0, 0, 6'd2, 6'd0);
      repeat (6) step(0, 1, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
